// File: rtl/cpu_pkg.sv
// Shared LSU definitions: access sizes, LSU state encoding and lane helpers.
package cpu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StMerge,
        StResp
    } lsu_state_e;

    // Bit mask of the lane addressed by (size, offset); size 11 behaves as a word.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_mask = 32'h0000_00FF << {off, 3'b000};
            SIZE_HALF: lane_mask = 32'h0000_FFFF << {off[1], 4'b0000};
            default:   lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        misaligned = ((size == SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_unit
    import cpu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] st_merged
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] st_rep;
    logic [31:0] st_mask;

    // Load path: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        byte_sh = ld_word >> {off, 3'b000};
        half_sh = ld_word >> {off[1], 4'b0000};
        case (size)
            SIZE_BYTE: ld_data = uns ? {24'b0, byte_sh[7:0]}
                                     : {{24{byte_sh[7]}}, byte_sh[7:0]};
            SIZE_HALF: ld_data = uns ? {16'b0, half_sh[15:0]}
                                     : {{16{half_sh[15]}}, half_sh[15:0]};
            default:   ld_data = ld_word;
        endcase
    end

    // Store path: replicate the data across lanes and keep only the addressed lane.
    always_comb begin
        case (size)
            SIZE_BYTE: st_rep = {4{st_wdata[7:0]}};
            SIZE_HALF: st_rep = {2{st_wdata[15:0]}};
            default:   st_rep = st_wdata;
        endcase
        st_mask   = lane_mask(size, off);
        st_merged = (st_old & ~st_mask) | (st_rep & st_mask);
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit driving a word-organised data memory with one request in flight.
module lsu_mem_initiator
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    input  logic [31:0]   mem_dout
);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          resp_valid_q, resp_valid_d;
    logic [AW-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;

    logic [31:0]   ld_data;
    logic [31:0]   st_merged;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW];

    lsu_lane_unit u_lane (
        .ld_word   (mem_dout),
        .st_old    (mem_dout),
        .st_wdata  (wdata_q),
        .off       (off_q),
        .size      (size_q),
        .uns       (uns_q),
        .ld_data   (ld_data),
        .st_merged (st_merged)
    );

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = 1'b0;
        mem_we_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'b0;
                    err_d   = 1'b0;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        err_d        = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end else begin
                        mem_addr_d = req_addr[AW-1:2];
                        state_d    = StAccess;
                        // Word stores write in the ACCESS cycle itself.
                        if (req_we && req_size[1]) begin
                            mem_we_d  = 1'b1;
                            mem_din_d = req_wdata;
                        end
                    end
                end
            end
            StAccess: begin
                if (!we_q) begin
                    rdata_d      = ld_data;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else if (size_q[1]) begin
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    // Old word is on mem_dout now; merged result is written next cycle.
                    mem_din_d = st_merged;
                    mem_we_d  = 1'b1;
                    state_d   = StMerge;
                end
            end
            StMerge: begin
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'b0;
            rdata_q      <= 32'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    // Gate with reset so an in-flight write is dropped on the reset edge.
    assign mem_we     = mem_we_q & rst_n;

endmodule
